// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS waveform generator.
package dds_pkg;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_mode_e;

  // Control fields that travel alongside the phase through the pipeline.
  typedef struct packed {
    wave_mode_e mode;
    logic [1:0] amp_shift;
    logic       valid;
  } stage_ctrl_t;

  localparam int unsigned DDS_LATENCY = 2;

  function automatic int unsigned midscale(input int unsigned dw);
    return 32'(1) << (dw - 1);
  endfunction

endpackage

// File: rtl/sine_rom_mp.sv
// Multi-port synchronous sine ROM; table is built at elaboration.
module sine_rom_mp
  import dds_pkg::*;
#(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned NCH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH*A_WIDTH-1:0]   addr,
  output logic [NCH*D_WIDTH-1:0]   data
);

  localparam int unsigned DEPTH = 32'(1) << A_WIDTH;
  localparam int unsigned MID   = midscale(D_WIDTH);

  logic [D_WIDTH-1:0] rom [DEPTH];

  // round(mid + (mid-1)*sin(2*pi*i/DEPTH)); int'() of a real rounds to nearest.
  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    localparam real ANG = 2.0 * 3.14159265358979323846 * real'(i) / real'(DEPTH);
    localparam int  VAL = int'(real'(MID) + real'(MID - 1) * $sin(ANG));
    assign rom[i] = D_WIDTH'(VAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        data[k*D_WIDTH +: D_WIDTH] <= rom[addr[k*A_WIDTH +: A_WIDTH]];
      end
    end
  end

endmodule

// File: rtl/dds_multigen.sv
// Multi-channel DDS: shared phase accumulator, per-channel offset, 2-stage
// waveform/amplitude pipeline.
module dds_multigen
  import dds_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned ACC_WIDTH = 16,
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned D_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [ACC_WIDTH-1:0]   freq_incr,
  input  logic [NCH*A_WIDTH-1:0] phase_offst,
  input  logic [1:0]             mode,
  input  logic [1:0]             amp_shift,
  output logic [NCH*D_WIDTH-1:0] dout,
  output logic                   dout_valid
);

  if (NCH < 1 || NCH > 8 || ACC_WIDTH < A_WIDTH || A_WIDTH < D_WIDTH || A_WIDTH < 2)
  begin : g_param_err
    $error("dds_multigen: illegal parameter combination");
  end

  localparam logic signed [D_WIDTH:0] MID = (D_WIDTH+1)'(midscale(D_WIDTH));

  logic [ACC_WIDTH-1:0]   acc;
  logic [A_WIDTH-1:0]     p;
  logic [NCH*A_WIDTH-1:0] p0_c;
  logic [A_WIDTH-1:0]     p1 [NCH];
  stage_ctrl_t            ctrl1;
  logic [NCH*D_WIDTH-1:0] rom_q;
  logic [D_WIDTH-1:0]     samp_c [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + freq_incr;
    end
  end

  // Stage 0: per-channel phase, offsets wrap within A_WIDTH bits.
  assign p = acc[ACC_WIDTH-1 -: A_WIDTH];

  always_comb begin
    p0_c = '0;
    for (int k = 0; k < NCH; k++) begin
      p0_c[k*A_WIDTH +: A_WIDTH] = p + phase_offst[k*A_WIDTH +: A_WIDTH];
    end
  end

  // Stage 1: phase and controls registered in step with the ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl1 <= '0;
      for (int k = 0; k < NCH; k++) p1[k] <= '0;
    end else begin
      ctrl1 <= '{mode: wave_mode_e'(mode), amp_shift: amp_shift, valid: en};
      for (int k = 0; k < NCH; k++) p1[k] <= p0_c[k*A_WIDTH +: A_WIDTH];
    end
  end

  sine_rom_mp #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .NCH     (NCH)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .addr (p0_c),
    .data (rom_q)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [D_WIDTH-1:0]      wave;
    logic [A_WIDTH-2:0]      tri_t;
    logic signed [D_WIDTH:0] s;
    logic signed [D_WIDTH:0] s_sh;

    // Waveform select, then attenuation about midscale.
    always_comb begin
      tri_t = p1[k][A_WIDTH-1] ? ~p1[k][A_WIDTH-2:0] : p1[k][A_WIDTH-2:0];
      case (ctrl1.mode)
        WAVE_SINE:   wave = rom_q[k*D_WIDTH +: D_WIDTH];
        WAVE_SQUARE: wave = p1[k][A_WIDTH-1] ? '0 : '1;
        WAVE_TRI:    wave = D_WIDTH'({tri_t, 1'b0} >> (A_WIDTH - D_WIDTH));
        default:     wave = D_WIDTH'(p1[k] >> (A_WIDTH - D_WIDTH));
      endcase
      s         = $signed({1'b0, wave}) - MID;
      s_sh      = s >>> ctrl1.amp_shift;
      samp_c[k] = D_WIDTH'(s_sh + MID);
    end
  end

  // Stage 2: output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) dout[k*D_WIDTH +: D_WIDTH] <= samp_c[k];
      dout_valid <= ctrl1.valid;
    end
  end

endmodule

// File: tb/tb_dds_multigen.sv
// Scoreboard bench for dds_multigen: per-cycle expected samples from a
// phase/trig reference model, checked by an independent monitor.
module tb_dds_multigen;

  localparam int unsigned NCH  = 2;
  localparam int unsigned ACCW = 16;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam real         PI   = 3.14159265358979323846;

  typedef struct {
    logic          v;
    logic [15:0]   d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [ACCW-1:0]   freq_incr = '0;
  logic [NCH*AW-1:0] phase_offst = '0;
  logic [1:0]        mode = '0;
  logic [1:0]        amp_shift = '0;
  logic [NCH*DW-1:0] dout;
  logic              dout_valid;

  exp_t        q[$];
  logic [15:0] acc_m = '0;
  bit          mon_en = 1'b0;
  int          vectors = 0;
  int          errors = 0;

  dds_multigen #(.NCH(NCH), .ACC_WIDTH(ACCW), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .freq_incr   (freq_incr),
    .phase_offst (phase_offst),
    .mode        (mode),
    .amp_shift   (amp_shift),
    .dout        (dout),
    .dout_valid  (dout_valid)
  );

  always #5 clk = ~clk;

  // Reference: one channel's sample for a given accumulator value.
  function automatic logic [7:0] ref_ch(input logic [15:0] acc, input int off,
                                        input int m, input int sh);
    int  pk, v, s;
    real x;
    pk = ((int'(acc) >> (ACCW - AW)) + off) % 256;
    case (m)
      0: begin
        x = 128.0 + 127.0 * $sin(2.0 * PI * real'(pk) / 256.0);
        v = int'($floor(x + 0.5));
      end
      1: v = (pk < 128) ? 255 : 0;
      2: v = (pk < 128) ? 2 * pk : 2 * (255 - pk);
      default: v = pk;
    endcase
    s = v - 128;
    s = s >>> sh;
    return 8'(s + 128);
  endfunction

  task automatic drive_cycle(input logic e, input logic [15:0] f, input logic [7:0] o0,
                             input logic [7:0] o1, input logic [1:0] m, input logic [1:0] sh);
    exp_t it;
    @(negedge clk);
    en = e; freq_incr = f; phase_offst = {o1, o0}; mode = m; amp_shift = sh;
    it.v = e;
    it.d = {ref_ch(acc_m, int'(o1), int'(m), int'(sh)), ref_ch(acc_m, int'(o0), int'(m), int'(sh))};
    q.push_back(it);
    if (e) acc_m = acc_m + f;
  endtask

  task automatic check_now(input string name, input logic v, input logic [15:0] d);
    vectors++;
    if (dout_valid !== v || dout !== d) begin
      errors++;
      $display("FAIL %s: got dout=%h valid=%b, expected dout=%h valid=%b",
               name, dout, dout_valid, d, v);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    @(posedge clk); #3;
    mon_en = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    #1;
    check_now("reset_async", 1'b0, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    acc_m = '0;
    mon_en = 1'b1;
  endtask

  // Monitor: entry pushed two cycles ago is on dout just after this edge.
  always begin
    exp_t it;
    @(posedge clk); #1;
    if (mon_en && q.size() >= 2) begin
      it = q.pop_front();
      vectors++;
      if (dout_valid !== it.v || dout !== it.d) begin
        errors++;
        $display("FAIL scoreboard@%0t: got dout=%h valid=%b, expected dout=%h valid=%b",
                 $time, dout, dout_valid, it.d, it.v);
      end
    end
  end

  int unsigned tab_m [12] = '{1, 2, 3, 1, 2, 3, 0, 0, 0, 0, 0, 0};
  int unsigned tab_o [12] = '{64, 64, 64, 192, 192, 192, 64, 64, 64, 64, 192, 0};
  int unsigned tab_s [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 0};
  int unsigned tab_e [12] = '{255, 128, 64, 0, 126, 192, 255, 191, 159, 143, 64, 128};

  initial begin
    logic [1:0]  rm, rs;
    logic [7:0]  r0, r1;
    logic [15:0] rf;
    logic [7:0]  te;
    #12;
    check_now("reset_state", 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Fixed-phase table: freq 0 keeps acc at 0, so phase = offset.
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < 3; c++)
        drive_cycle(1'b1, 16'h0000, 8'(tab_o[i]), 8'(tab_o[i]), 2'(tab_m[i]), 2'(tab_s[i]));
      te = 8'(tab_e[i]);
      check_now($sformatf("table%0d", i), 1'b1, {te, te});
    end

    // Sine sweep from reset, offsets 0/64, through the 255->0 wrap.
    do_reset();
    for (int c = 0; c < 3; c++) drive_cycle(1'b1, 16'h0100, 8'd0, 8'd64, 2'd0, 2'd0);
    check_now("sweep_first", 1'b1, 16'hFF80);
    for (int c = 0; c < 290; c++) drive_cycle(1'b1, 16'h0100, 8'd0, 8'd64, 2'd0, 2'd0);

    // Fractional rate with a 3-cycle enable gap.
    for (int c = 0; c < 40; c++)
      drive_cycle((c >= 15 && c < 18) ? 1'b0 : 1'b1, 16'h0080, 8'd0, 8'd64, 2'd0, 2'd0);

    // Mode switch mid-stream.
    for (int c = 0; c < 24; c++)
      drive_cycle(1'b1, 16'h0100, 8'd3, 8'd3, (c < 12) ? 2'd0 : 2'd3, 2'd0);

    // Randomised run with a reset pulse in the middle.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      if (c % 7 == 0) begin
        rf = 16'($urandom_range(0, 16'hFFFF));
        r0 = 8'($urandom_range(0, 255));
        r1 = ($urandom_range(0, 3) == 0) ? r0 : 8'($urandom_range(0, 255));
      end
      rm = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      drive_cycle(($urandom_range(0, 4) != 0), rf, r0, r1, rm, rs);
    end

    for (int c = 0; c < 3; c++) drive_cycle(1'b0, 16'h0000, 8'd0, 8'd0, 2'd0, 2'd0);
    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
